amm_byte_inc_dispatch: RTL and testbench
========================================

AMM_BYTE_INC_DISPATCH -- requirements
Module: amm_byte_inc_dispatch

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 64, meaning the byte_inc Avalon-MM data width in bits; BYTE_CNT = DATA_WIDTH/8.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 10, meaning the byte_inc word address width.
REQ-003 The module SHALL have parameter QUEUE_DEPTH, default 4, meaning the job FIFO depth (power of two, >=2).
REQ-004 The module SHALL have a single clock and a synchronous, active-high reset; other widths: LW = ADDR_WIDTH+$clog2(BYTE_CNT), CW = $clog2(QUEUE_DEPTH)+1.
REQ-005 Ports SHALL be (name direction width meaning):
 clk_i  in  1  clock
 srst_i  in  1  synchronous active-high reset
 job_valid_i  in  1  job offered
 job_ready_o  out  1  job accepted when valid&ready
 job_base_addr_i  in  ADDR_WIDTH  start word address
 job_length_i  in  LW  length in bytes
 job_err_o  out  1  one-cycle pulse: job rejected
 base_addr_o  out  ADDR_WIDTH  to byte_inc
 length_o  out  LW  to byte_inc
 run_o  out  1  one-cycle start pulse to byte_inc
 waitrequest_i  in  1  byte_inc busy
 pending_o  out  CW  jobs queued, excluding the in-flight job
 busy_o  out  1  a job is in flight

Function
REQ-006 A job SHALL be accepted on a clk_i edge where job_valid_i and job_ready_o are both high; job_ready_o = !fifo_full, combinational from registered state only.
REQ-007 An accepted job SHALL be rejected (not enqueued; job_err_o high the next cycle) when job_length_i == 0 or base*BYTE_CNT + length > 2**ADDR_WIDTH*BYTE_CNT.
REQ-008 Arithmetic for REQ-007 SHALL be at LW+1 bits so no wrap-around; the exact-fit case (e.g. base 0x3FF, length 8, BYTE_CNT 8) SHALL be accepted.
REQ-009 FSM states SHALL be IDLE, ISSUE, WAIT_ACK, BUSY.
REQ-010 IDLE -> ISSUE when the FIFO is non-empty and waitrequest_i is low; the head is popped and latched into base_addr_o/length_o on this transition.
REQ-011 In ISSUE, run_o SHALL be high for exactly one cycle, then the FSM enters WAIT_ACK.
REQ-012 WAIT_ACK -> BUSY when waitrequest_i is high; BUSY -> IDLE when waitrequest_i is low.
REQ-013 base_addr_o and length_o SHALL be stable from ISSUE until return to IDLE.
REQ-014 busy_o SHALL be high in ISSUE, WAIT_ACK and BUSY.
REQ-015 Simultaneous push and pop SHALL leave pending_o unchanged; a push while full is impossible because ready is low.
REQ-016 Issue-to-issue latency SHALL be at least 1 idle cycle after waitrequest_i falls.
REQ-017 FIFO pointers SHALL wrap modulo QUEUE_DEPTH.

Reset
REQ-018 On srst_i, the FSM SHALL go to IDLE and the FIFO SHALL be emptied.
REQ-019 On srst_i, the outputs SHALL take these values: run_o=0, job_err_o=0, busy_o=0, pending_o=0, base_addr_o=0, length_o=0, job_ready_o=1 from the first cycle after reset.
REQ-020 Reset mid-job SHALL drop the in-flight job and all queued jobs with no run_o pulse.

Configuration
REQ-021 With macro DISPATCH_WATCHDOG_EN defined, a 16-bit counter SHALL count cycles in WAIT_ACK; reaching 1023 SHALL return the FSM to IDLE and pulse job_err_o for one cycle.
REQ-022 Without DISPATCH_WATCHDOG_EN, WAIT_ACK SHALL wait indefinitely and no counter SHALL be synthesized.

Structure
REQ-023 The FSM state enum and the default parameter constants SHALL live in package amm_byte_inc_dispatch_pkg.
REQ-024 The job FIFO SHALL be sub-module amm_byte_inc_dispatch_fifo: a show-ahead register FIFO with push, pop, full, empty and usedw.

Verification
REQ-025 A bench SHALL run a single job (base 0x010, length 20) with waitrequest_i high 1 cycle after run_o for 5 cycles: exactly one run_o pulse, outputs 0x010/20, busy_o falls 1 cycle after waitrequest_i.
REQ-026 A bench SHALL push 4 jobs back-to-back, then a 5th, while byte_inc is busy: job_ready_o is low on the 5th and pending_o==4; the jobs issue in FIFO order.
REQ-027 A bench SHALL offer an oversize job (base 0x3FF, length 9) and an exact-fit job (base 0x3FF, length 8): the first gives a job_err_o pulse and no enqueue; the second is accepted.
REQ-028 A bench SHALL hold waitrequest_i high when a job is queued: no run_o until waitrequest_i falls, then run_o one cycle later.
REQ-029 A bench SHALL assert srst_i in BUSY with 2 jobs pending: pending_o=0, busy_o=0, and no further run_o.
REQ-030 With DISPATCH_WATCHDOG_EN, a bench SHALL hold waitrequest_i low after run_o: job_err_o pulses after 1023 cycles and the next job then issues.

Source files
------------

// File: rtl/amm_byte_inc_dispatch_pkg.sv
// Shared types and default sizing for the byte_inc job dispatcher.
package amm_byte_inc_dispatch_pkg;

    localparam int unsigned DEF_DATA_WIDTH  = 64;
    localparam int unsigned DEF_ADDR_WIDTH  = 10;
    localparam int unsigned DEF_QUEUE_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2,
        BUSY     = 2'd3
    } state_e;

endpackage

// File: rtl/amm_byte_inc_dispatch_fifo.sv
// Show-ahead register FIFO holding pending byte_inc jobs.
module amm_byte_inc_dispatch_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = PW + 1
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    usedw_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign usedw_o = cnt_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/amm_byte_inc_dispatch.sv
// Queues byte_inc jobs, range-checks them and issues them one at a time.
// Optional WAIT_ACK watchdog enabled by defining DISPATCH_WATCHDOG_EN.
module amm_byte_inc_dispatch
    import amm_byte_inc_dispatch_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter  int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter  int unsigned QUEUE_DEPTH = DEF_QUEUE_DEPTH,
    localparam int unsigned BYTE_CNT    = DATA_WIDTH / 8,
    localparam int unsigned LW          = ADDR_WIDTH + $clog2(BYTE_CNT),
    localparam int unsigned CW          = $clog2(QUEUE_DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic                  job_valid_i,
    output logic                  job_ready_o,
    input  logic [ADDR_WIDTH-1:0] job_base_addr_i,
    input  logic [LW-1:0]         job_length_i,
    output logic                  job_err_o,
    output logic [ADDR_WIDTH-1:0] base_addr_o,
    output logic [LW-1:0]         length_o,
    output logic                  run_o,
    input  logic                  waitrequest_i,
    output logic [CW-1:0]         pending_o,
    output logic                  busy_o
);

    localparam int unsigned JW  = ADDR_WIDTH + LW;
    localparam int unsigned BSH = $clog2(BYTE_CNT);
    localparam logic [LW:0] LIMIT = (LW+1)'(1) << LW;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [LW-1:0]         len_q, len_d;
    logic                  run_q, run_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;

    logic                  fifo_full, fifo_empty, fifo_pop;
    logic [JW-1:0]         fifo_dout;
    logic [ADDR_WIDTH-1:0] head_base;
    logic [LW-1:0]         head_len;
    logic [LW:0]           job_end;
    logic                  job_accept, job_bad, job_push, job_reject;

    assign job_ready_o = !fifo_full;

    // One extra bit keeps base*BYTE_CNT + length from wrapping, so exact fit passes.
    assign job_end    = ((LW+1)'(job_base_addr_i) << BSH) + (LW+1)'(job_length_i);
    assign job_accept = job_valid_i && job_ready_o;
    assign job_bad    = (job_length_i == '0) || (job_end > LIMIT);
    assign job_push   = job_accept && !job_bad;
    assign job_reject = job_accept && job_bad;

    amm_byte_inc_dispatch_fifo #(
        .WIDTH (JW),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .srst_i  (srst_i),
        .push_i  (job_push),
        .data_i  ({job_base_addr_i, job_length_i}),
        .pop_i   (fifo_pop),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .usedw_o (pending_o)
    );

    assign {head_base, head_len} = fifo_dout;

`ifdef DISPATCH_WATCHDOG_EN
    localparam logic [15:0] WD_LAST = 16'd1022;
    logic [15:0] wd_cnt_q, wd_cnt_d;
`endif

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        fifo_pop = 1'b0;
        err_d    = job_reject;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !waitrequest_i) begin
                    fifo_pop = 1'b1;
                    base_d   = head_base;
                    len_d    = head_len;
                    state_d  = ISSUE;
                end
            end
            ISSUE: state_d = WAIT_ACK;
            WAIT_ACK: begin
                if (waitrequest_i) begin
                    state_d = BUSY;
                end
`ifdef DISPATCH_WATCHDOG_EN
                else if (wd_cnt_q == WD_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
`endif
            end
            BUSY: begin
                if (!waitrequest_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        run_d  = (state_d == ISSUE);
        busy_d = (state_d != IDLE);
    end

`ifdef DISPATCH_WATCHDOG_EN
    // Counts consecutive cycles spent waiting for byte_inc to acknowledge.
    always_comb begin
        wd_cnt_d = 16'd0;
        if (state_q == WAIT_ACK && state_d == WAIT_ACK) begin
            wd_cnt_d = wd_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= IDLE;
            base_q  <= '0;
            len_q   <= '0;
            run_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            run_q   <= run_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign base_addr_o = base_q;
    assign length_o    = len_q;
    assign run_o       = run_q;
    assign busy_o      = busy_q;
    assign job_err_o   = err_q;

endmodule

// File: tb/tb_amm_byte_inc_dispatch.sv
// Directed bench for amm_byte_inc_dispatch: range-check table plus issue sequences.
module tb_amm_byte_inc_dispatch;

    logic        clk;
    logic        srst;
    logic        job_valid;
    logic        job_ready;
    logic [9:0]  job_base;
    logic [12:0] job_len;
    logic        job_err;
    logic [9:0]  base_addr;
    logic [12:0] length;
    logic        run;
    logic        wr;
    logic [2:0]  pending;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int run_cnt = 0;
    int run_mark;
    bit seen;

    typedef struct {
        logic [9:0]  base;
        logic [12:0] len;
        logic        err;
        logic [2:0]  pend;
    } vec_t;
    vec_t vecs[9];

    amm_byte_inc_dispatch dut (
        .clk_i           (clk),
        .srst_i          (srst),
        .job_valid_i     (job_valid),
        .job_ready_o     (job_ready),
        .job_base_addr_i (job_base),
        .job_length_i    (job_len),
        .job_err_o       (job_err),
        .base_addr_o     (base_addr),
        .length_o        (length),
        .run_o           (run),
        .waitrequest_i   (wr),
        .pending_o       (pending),
        .busy_o          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (run === 1'b1) run_cnt++;

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        srst = 1'b1;
        job_valid = 1'b0;
        step();
        step();
        srst = 1'b0;
    endtask

    task automatic push(input logic [9:0] b, input logic [12:0] l);
        job_valid = 1'b1;
        job_base  = b;
        job_len   = l;
        step();
        job_valid = 1'b0;
    endtask

    task automatic wait_run(input int budget, output bit ok);
        for (int i = 0; i < budget; i++) begin
            if (run === 1'b1) break;
            step();
        end
        ok = (run === 1'b1);
    endtask

    // Acts as byte_inc for one job: checks the issued payload, then busy for two cycles.
    task automatic serve(input logic [9:0] b, input logic [12:0] l);
        bit ok;
        wait_run(20, ok);
        chk("serve_run_seen", 32'(ok), 32'd1);
        chk("serve_base", 32'(base_addr), 32'(b));
        chk("serve_len", 32'(length), 32'(l));
        wr = 1'b1;
        step();
        step();
        wr = 1'b0;
        step();
    endtask

    initial begin
        srst = 1'b0;
        job_valid = 1'b0;
        job_base = '0;
        job_len = '0;
        wr = 1'b0;

        vecs[0] = '{10'h000, 13'd0,      1'b1, 3'd0};
        vecs[1] = '{10'h3FF, 13'd9,      1'b1, 3'd0};
        vecs[2] = '{10'h3FF, 13'd8,      1'b0, 3'd1};
        vecs[3] = '{10'h000, 13'h1FFF,   1'b0, 3'd2};
        vecs[4] = '{10'h001, 13'h1FF9,   1'b1, 3'd2};
        vecs[5] = '{10'h001, 13'h1FF8,   1'b0, 3'd3};
        vecs[6] = '{10'h200, 13'h1001,   1'b1, 3'd3};
        vecs[7] = '{10'h3FF, 13'h1FFF,   1'b1, 3'd3};
        vecs[8] = '{10'h100, 13'd1,      1'b0, 3'd4};

        do_reset();
        chk("rst_run", 32'(run), 32'd0);
        chk("rst_err", 32'(job_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_base", 32'(base_addr), 32'd0);
        chk("rst_len", 32'(length), 32'd0);
        chk("rst_ready", 32'(job_ready), 32'd1);

        // Range-check table; waitrequest held high so nothing leaves the queue.
        wr = 1'b1;
        for (int i = 0; i < 9; i++) begin
            push(vecs[i].base, vecs[i].len);
            chk($sformatf("vec%0d_err", i), 32'(job_err), 32'(vecs[i].err));
            chk($sformatf("vec%0d_pending", i), 32'(pending), 32'(vecs[i].pend));
        end
        chk("vec_full_ready", 32'(job_ready), 32'd0);
        chk("vec_no_run", 32'(run_cnt), 32'd0);
        wr = 1'b0;
        do_reset();

        // Single job with a 5-cycle busy window.
        run_mark = run_cnt;
        push(10'h010, 13'd20);
        wait_run(5, seen);
        chk("single_run_seen", 32'(seen), 32'd1);
        chk("single_base", 32'(base_addr), 32'h010);
        chk("single_len", 32'(length), 32'd20);
        chk("single_busy_issue", 32'(busy), 32'd1);
        step();
        chk("single_run_width", 32'(run), 32'd0);
        wr = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("single_busy_held", 32'(busy), 32'd1);
        chk("single_base_stable", 32'(base_addr), 32'h010);
        wr = 1'b0;
        step();
        chk("single_busy_fall", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) step();
        chk("single_run_count", 32'(run_cnt - run_mark), 32'd1);

        // Fill the queue while byte_inc is busy, offer a 5th, then drain in order.
        do_reset();
        run_mark = run_cnt;
        wr = 1'b1;
        push(10'h001, 13'd1);
        push(10'h002, 13'd2);
        push(10'h003, 13'd3);
        push(10'h004, 13'd4);
        chk("fill_pending", 32'(pending), 32'd4);
        chk("fill_ready_low", 32'(job_ready), 32'd0);
        push(10'h005, 13'd5);
        chk("fill_5th_pending", 32'(pending), 32'd4);
        chk("fill_5th_err", 32'(job_err), 32'd0);
        wr = 1'b0;
        wait_run(5, seen);
        chk("drain_pending_after_pop", 32'(pending), 32'd3);
        serve(10'h001, 13'd1);
        serve(10'h002, 13'd2);
        serve(10'h003, 13'd3);
        serve(10'h004, 13'd4);
        for (int i = 0; i < 5; i++) step();
        chk("drain_run_count", 32'(run_cnt - run_mark), 32'd4);
        chk("drain_pending_empty", 32'(pending), 32'd0);
        chk("drain_busy_idle", 32'(busy), 32'd0);

        // Job held off by waitrequest until it drops.
        do_reset();
        run_mark = run_cnt;
        wr = 1'b1;
        push(10'h020, 13'd16);
        for (int i = 0; i < 5; i++) step();
        chk("hold_no_run", 32'(run_cnt - run_mark), 32'd0);
        chk("hold_pending", 32'(pending), 32'd1);
        chk("hold_busy", 32'(busy), 32'd0);
        wr = 1'b0;
        step();
        chk("hold_run_next", 32'(run), 32'd1);
        chk("hold_base", 32'(base_addr), 32'h020);
        wr = 1'b1;
        step();
        step();
        wr = 1'b0;
        step();
        chk("hold_done", 32'(busy), 32'd0);

        // Reset while BUSY with two jobs queued.
        do_reset();
        push(10'h030, 13'd8);
        wait_run(5, seen);
        chk("rstbusy_run_seen", 32'(seen), 32'd1);
        wr = 1'b1;
        push(10'h031, 13'd8);
        push(10'h032, 13'd8);
        chk("rstbusy_busy", 32'(busy), 32'd1);
        chk("rstbusy_pending", 32'(pending), 32'd2);
        srst = 1'b1;
        step();
        srst = 1'b0;
        wr = 1'b0;
        run_mark = run_cnt;
        chk("rstbusy_pending_clr", 32'(pending), 32'd0);
        chk("rstbusy_busy_clr", 32'(busy), 32'd0);
        chk("rstbusy_base_clr", 32'(base_addr), 32'd0);
        chk("rstbusy_ready", 32'(job_ready), 32'd1);
        for (int i = 0; i < 10; i++) step();
        chk("rstbusy_no_run", 32'(run_cnt - run_mark), 32'd0);

`ifdef DISPATCH_WATCHDOG_EN
        // No acknowledge: watchdog aborts, then the queued job issues.
        begin
            int n;
            do_reset();
            push(10'h040, 13'd8);
            wait_run(5, seen);
            push(10'h041, 13'd8);
            n = 1;
            while (job_err !== 1'b1 && n < 1100) begin
                step();
                n++;
            end
            chk("wd_err_cycles", 32'(n), 32'd1024);
            step();
            chk("wd_err_width", 32'(job_err), 32'd0);
            chk("wd_next_run", 32'(run), 32'd1);
            chk("wd_next_base", 32'(base_addr), 32'h041);
        end
`else
        // No acknowledge: the dispatcher keeps waiting without error.
        do_reset();
        push(10'h040, 13'd8);
        wait_run(5, seen);
        for (int i = 0; i < 1100; i++) step();
        chk("nowd_busy", 32'(busy), 32'd1);
        chk("nowd_no_err", 32'(job_err), 32'd0);
        wr = 1'b1;
        step();
        step();
        wr = 1'b0;
        step();
        chk("nowd_done", 32'(busy), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
